// File: rtl/data_memory.sv
// data_memory: 2048 x 16 word-addressed synchronous memory that answers the
// accumulator CPU's memory bus, with a boot loader that streams a program
// image into the array from address 0 while CPU accesses are held off.
//
// Optional feature macro: DATA_MEMORY_WRPROT_EN
//   defined   -> CPU writes below PROG_LIMIT are discarded and set sticky protErr
//   undefined -> every CPU write is performed, protErr is tied to 0
//
// Loader handshake: a word transfers on every posedge where loadValid and
// loadReady are both 1; loadReady is 1 for the whole LOAD state and the
// loader never stalls, so loadValid alone paces the image.
//
// dbg_state exposes the loader FSM state (0 IDLE, 1 LOAD, 2 DONE).
module data_memory #(
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 16,
  parameter int DEPTH      = 2048,
  parameter int PROG_LIMIT = 64
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic [ADDR_W-1:0] memoryAddress,
  input  logic [DATA_W-1:0] dataIn,
  input  logic              readSignal,
  input  logic              writeSignal,
  output logic [DATA_W-1:0] memoryData,
  input  logic              loadStart,
  input  logic              loadValid,
  input  logic [DATA_W-1:0] loadData,
  input  logic              loadLast,
  output logic              loadReady,
  output logic              busy,
  output logic              loadDone,
  output logic              protErr,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  // The array is addressed directly by ADDR_W bits, so it must be fully populated.
  if (DEPTH != (1 << ADDR_W) || PROG_LIMIT > DEPTH) begin : g_cfg_check
    $error("data_memory: DEPTH must equal 2**ADDR_W and PROG_LIMIT must not exceed DEPTH");
  end

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] ptr_nxt;
  logic              cpu_en;
  logic              ld_wr;
  logic              cpu_wr;
  logic              prot_hit;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  logic [DATA_W-1:0] mem [DEPTH];

  assign dbg_state = state;

  // Loader FSM state and write pointer register.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state <= ST_IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // Loader next-state, pointer advance and status outputs.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    busy      = 1'b0;
    loadReady = 1'b0;
    loadDone  = 1'b0;
    ld_wr     = 1'b0;
    cpu_en    = 1'b0;
    case (state)
      ST_IDLE: begin
        cpu_en = 1'b1;
        if (loadStart) begin
          state_nxt = ST_LOAD;
          ptr_nxt   = '0;
        end
      end
      ST_LOAD: begin
        busy      = 1'b1;
        loadReady = 1'b1;
        if (loadValid) begin
          ld_wr = 1'b1;
          // The pointer stops at the last word instead of wrapping back to 0.
          if (loadLast || ptr == LAST_ADDR) begin
            state_nxt = ST_DONE;
          end else begin
            ptr_nxt = ptr + 1'b1;
          end
        end
      end
      ST_DONE: begin
        loadDone  = 1'b1;
        cpu_en    = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

`ifdef DATA_MEMORY_WRPROT_EN
  localparam logic [ADDR_W-1:0] PROG_LIMIT_A = ADDR_W'(PROG_LIMIT);

  assign prot_hit = (memoryAddress < PROG_LIMIT_A);

  // Sticky flag for CPU writes that tried to overwrite the program region.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      protErr <= 1'b0;
    end else if (cpu_en && writeSignal && prot_hit) begin
      protErr <= 1'b1;
    end
  end
`else
  assign prot_hit = 1'b0;
  assign protErr  = 1'b0;
`endif

  // One shared write port: loader writes only in LOAD, CPU writes only outside it.
  assign cpu_wr    = cpu_en && writeSignal && !prot_hit;
  assign mem_we    = ld_wr || cpu_wr;
  assign mem_addr  = ld_wr ? ptr : memoryAddress;
  assign mem_wdata = ld_wr ? loadData : dataIn;

  // Array write; nothing is written while reset is held.
  always_ff @(posedge clk) begin
    if (resetN && mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  // Registered read port; a write in the same cycle wins and the output holds.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      memoryData <= '0;
    end else if (cpu_en && readSignal && !writeSignal) begin
      memoryData <= mem[memoryAddress];
    end
  end

endmodule
